// File: rtl/lcd_bus_monitor.sv
// lcd_bus_monitor
// Receiving end of an HD44780-style character-LCD write bus. The LCD pins are
// oversampled on CLK, each falling edge of LCD_E is decoded as an instruction
// or a character write, and a 2x16 shadow of the visible DDRAM is kept along
// with cursor, mode and emulated busy state.
//
// Ports
//   CLK, RESETN          system clock, asynchronous active-low reset
//   LCD_E/RS/RW/DATA     raw LCD bus pins (asynchronous to CLK)
//   RD_ADDR / RD_DATA    combinational shadow read (0-15 line 1, 16-31 line 2)
//   CURSOR               DDRAM address counter
//   DISP_ON, ENTRY_ID    display-on bit, entry-mode increment/decrement
//   FUNC                 {DL,N,F} from the last Function Set
//   BUSY                 emulated busy flag
//   EVT_VALID/RS/DATA    one-cycle pulse plus payload per accepted write
//   ERR                  sticky: transfer while busy, or instruction 0x00
//   DBG_STATE            current FSM state (IDLE=0, CLEARING=1, BUSY=2)
//
// Handshake: there is no back-pressure. EVT_VALID is a single-cycle strobe;
// EVT_RS/EVT_DATA are valid in that cycle and hold until the next accepted
// transfer. A transfer seen while BUSY is high is dropped and flagged in ERR.
module lcd_bus_monitor #(
    parameter int unsigned BUSY_CYC = 37,
    parameter int unsigned CLR_CYC  = 1520
) (
    input  logic       CLK,
    input  logic       RESETN,
    input  logic       LCD_E,
    input  logic       LCD_RS,
    input  logic       LCD_RW,
    input  logic [7:0] LCD_DATA,
    input  logic [4:0] RD_ADDR,
    output logic [7:0] RD_DATA,
    output logic [6:0] CURSOR,
    output logic       DISP_ON,
    output logic       ENTRY_ID,
    output logic [2:0] FUNC,
    output logic       BUSY,
    output logic       EVT_VALID,
    output logic       EVT_RS,
    output logic [7:0] EVT_DATA,
    output logic       ERR,
    output logic [1:0] DBG_STATE
);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_CLEARING = 2'd1,
        S_BUSY     = 2'd2
    } state_e;

    // Three-stage synchronisers. Stage 3 of RS/RW/DATA lines up with the
    // last cycle E was seen high when the falling edge is detected.
    logic [2:0]  e_sync_q;
    logic [2:0]  rs_sync_q;
    logic [2:0]  rw_sync_q;
    logic [7:0]  data_s1_q, data_s2_q, data_s3_q;

    state_e      state_q, state_d;
    logic [31:0] cnt_q, cnt_d;
    logic [4:0]  clr_idx_q, clr_idx_d;
    logic [6:0]  cursor_q, cursor_d;
    logic        disp_q, disp_d;
    logic        entry_q, entry_d;
    logic [2:0]  func_q, func_d;
    logic        err_q, err_d;
    logic        evt_valid_q, evt_valid_d;
    logic        evt_rs_q, evt_rs_d;
    logic [7:0]  evt_data_q, evt_data_d;
    logic [7:0]  shadow_q [32];

    logic        wr_en;
    logic [4:0]  wr_idx;
    logic [7:0]  wr_val;
    logic        load_busy;
    logic        fall;
    logic        rs_s;
    logic        rw_s;

    assign fall = e_sync_q[2] & ~e_sync_q[1];
    assign rs_s = rs_sync_q[2];
    assign rw_s = rw_sync_q[2];

    // Two-line DDRAM map: 0x00-0x27 and 0x40-0x67 wrap into each other.
    function automatic logic [6:0] step_ac(input logic [6:0] ac, input logic inc);
        if (inc) begin
            if (ac == 7'h27)      step_ac = 7'h40;
            else if (ac == 7'h67) step_ac = 7'h00;
            else                  step_ac = ac + 7'd1;
        end else begin
            if (ac == 7'h00)      step_ac = 7'h67;
            else if (ac == 7'h40) step_ac = 7'h27;
            else                  step_ac = ac - 7'd1;
        end
    endfunction

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            e_sync_q  <= '0;
            rs_sync_q <= '0;
            rw_sync_q <= '0;
            data_s1_q <= '0;
            data_s2_q <= '0;
            data_s3_q <= '0;
        end else begin
            e_sync_q  <= {e_sync_q[1:0], LCD_E};
            rs_sync_q <= {rs_sync_q[1:0], LCD_RS};
            rw_sync_q <= {rw_sync_q[1:0], LCD_RW};
            data_s1_q <= LCD_DATA;
            data_s2_q <= data_s1_q;
            data_s3_q <= data_s2_q;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        clr_idx_d   = clr_idx_q;
        cursor_d    = cursor_q;
        disp_d      = disp_q;
        entry_d     = entry_q;
        func_d      = func_q;
        err_d       = err_q;
        evt_valid_d = 1'b0;
        evt_rs_d    = evt_rs_q;
        evt_data_d  = evt_data_q;
        wr_en       = 1'b0;
        wr_idx      = 5'd0;
        wr_val      = 8'h20;
        load_busy   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (fall && !rw_s) begin
                    evt_valid_d = 1'b1;
                    evt_rs_d    = rs_s;
                    evt_data_d  = data_s3_q;
                    load_busy   = 1'b1;
                    if (rs_s) begin
                        if (cursor_q[6:4] == 3'b000) begin
                            wr_en  = 1'b1;
                            wr_idx = {1'b0, cursor_q[3:0]};
                        end else if (cursor_q[6:4] == 3'b100) begin
                            wr_en  = 1'b1;
                            wr_idx = {1'b1, cursor_q[3:0]};
                        end
                        wr_val   = data_s3_q;
                        cursor_d = step_ac(cursor_q, entry_q);
                    end else if (data_s3_q[7]) begin
                        cursor_d = data_s3_q[6:0];
                    end else if (data_s3_q[6]) begin
                        // CGRAM address is not modelled.
                    end else if (data_s3_q[5]) begin
                        func_d = data_s3_q[4:2];
                    end else if (data_s3_q[4]) begin
                        cursor_d = step_ac(cursor_q, data_s3_q[2]);
                    end else if (data_s3_q[3]) begin
                        disp_d = data_s3_q[2];
                    end else if (data_s3_q[2]) begin
                        entry_d = data_s3_q[1];
                    end else if (data_s3_q[1]) begin
                        cursor_d  = 7'h00;
                        load_busy = 1'b0;
                        state_d   = S_BUSY;
                        cnt_d     = 32'(CLR_CYC - 1);
                    end else if (data_s3_q[0]) begin
                        cursor_d  = 7'h00;
                        entry_d   = 1'b1;
                        load_busy = 1'b0;
                        state_d   = S_CLEARING;
                        clr_idx_d = 5'd0;
                    end else begin
                        err_d     = 1'b1;
                        load_busy = 1'b0;
                    end
                    if (load_busy && (BUSY_CYC != 0)) begin
                        state_d = S_BUSY;
                        cnt_d   = 32'(BUSY_CYC - 1);
                    end
                end
            end
            S_CLEARING: begin
                if (fall) err_d = 1'b1;
                wr_en  = 1'b1;
                wr_idx = clr_idx_q;
                wr_val = 8'h20;
                if (clr_idx_q == 5'd31) begin
                    // The 32 clearing cycles count toward the CLR_CYC total.
                    if (CLR_CYC > 32) begin
                        state_d = S_BUSY;
                        cnt_d   = 32'(CLR_CYC - 33);
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    clr_idx_d = clr_idx_q + 5'd1;
                end
            end
            S_BUSY: begin
                if (fall) err_d = 1'b1;
                if (cnt_q == 32'd0) state_d = S_IDLE;
                else                cnt_d   = cnt_q - 32'd1;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            clr_idx_q   <= '0;
            cursor_q    <= '0;
            disp_q      <= 1'b0;
            entry_q     <= 1'b1;
            func_q      <= '0;
            err_q       <= 1'b0;
            evt_valid_q <= 1'b0;
            evt_rs_q    <= 1'b0;
            evt_data_q  <= '0;
            for (int i = 0; i < 32; i++) shadow_q[i] <= 8'h20;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            clr_idx_q   <= clr_idx_d;
            cursor_q    <= cursor_d;
            disp_q      <= disp_d;
            entry_q     <= entry_d;
            func_q      <= func_d;
            err_q       <= err_d;
            evt_valid_q <= evt_valid_d;
            evt_rs_q    <= evt_rs_d;
            evt_data_q  <= evt_data_d;
            if (wr_en) shadow_q[wr_idx] <= wr_val;
        end
    end

    assign RD_DATA   = shadow_q[RD_ADDR];
    assign CURSOR    = cursor_q;
    assign DISP_ON   = disp_q;
    assign ENTRY_ID  = entry_q;
    assign FUNC      = func_q;
    assign BUSY      = (state_q != S_IDLE);
    assign EVT_VALID = evt_valid_q;
    assign EVT_RS    = evt_rs_q;
    assign EVT_DATA  = evt_data_q;
    assign ERR       = err_q;
    assign DBG_STATE = state_q;

endmodule

// File: tb/tb_lcd_bus_monitor.sv
module tb_lcd_bus_monitor;

    logic       clk;
    logic       rst_n;
    logic       lcd_e;
    logic       lcd_rs;
    logic       lcd_rw;
    logic [7:0] lcd_data;
    logic [4:0] rd_addr;
    logic [7:0] rd_data;
    logic [6:0] cursor;
    logic       disp_on;
    logic       entry_id;
    logic [2:0] func;
    logic       busy;
    logic       evt_valid;
    logic       evt_rs;
    logic [7:0] evt_data;
    logic       err;
    logic [1:0] dbg_state;

    logic [8:0] exp_q[$];
    int         checks = 0;
    int         fails  = 0;

    lcd_bus_monitor #(.BUSY_CYC(37), .CLR_CYC(1520)) dut (
        .CLK(clk), .RESETN(rst_n),
        .LCD_E(lcd_e), .LCD_RS(lcd_rs), .LCD_RW(lcd_rw), .LCD_DATA(lcd_data),
        .RD_ADDR(rd_addr), .RD_DATA(rd_data),
        .CURSOR(cursor), .DISP_ON(disp_on), .ENTRY_ID(entry_id), .FUNC(func),
        .BUSY(busy), .EVT_VALID(evt_valid), .EVT_RS(evt_rs), .EVT_DATA(evt_data),
        .ERR(err), .DBG_STATE(dbg_state)
    );

    // Clock and watchdog
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every EVT_VALID pulse is matched against the expected queue.
    always @(negedge clk) begin
        if (rst_n && evt_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                fails++;
                $display("FAIL evt_unexpected: got rs=%0b data=0x%0h expected none", evt_rs, evt_data);
            end else begin
                check("evt", {23'd0, evt_rs, evt_data}, {23'd0, exp_q.pop_front()});
            end
        end
    end

    // Driver: data set up 3 cycles before E rises, E high 4 cycles, then E
    // falls and the task idles for gap cycles.
    task automatic bus_write(input logic rs, input logic rw, input logic [7:0] d,
                             input int gap, input logic expect_evt);
        @(negedge clk);
        lcd_rs = rs; lcd_rw = rw; lcd_data = d; lcd_e = 1'b0;
        repeat (3) @(negedge clk);
        lcd_e = 1'b1;
        repeat (4) @(negedge clk);
        if (expect_evt) exp_q.push_back({rs, d});
        lcd_e = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    task automatic instr(input logic [7:0] d);
        bus_write(1'b0, 1'b0, d, 40, 1'b1);
    endtask

    task automatic wdata(input logic [7:0] d);
        bus_write(1'b1, 1'b0, d, 40, 1'b1);
    endtask

    task automatic check_shadow(input int idx, input logic [7:0] exp);
        rd_addr = 5'(idx);
        #1;
        check($sformatf("shadow[%0d]", idx), {24'd0, rd_data}, {24'd0, exp});
    endtask

    // Counts the cycles BUSY is high after a transfer was just issued.
    task automatic measure_busy(output int n);
        n = 0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (busy) n++;
            else if (n > 0) break;
        end
    endtask

    int nbusy;
    int waited;

    initial begin
        rst_n = 1'b0; lcd_e = 1'b0; lcd_rs = 1'b0; lcd_rw = 1'b0;
        lcd_data = 8'h00; rd_addr = 5'd0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Reset state
        check("rst_cursor", {25'd0, cursor}, 32'h00);
        check("rst_disp", {31'd0, disp_on}, 32'd0);
        check("rst_entry", {31'd0, entry_id}, 32'd1);
        check("rst_func", {29'd0, func}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_err", {31'd0, err}, 32'd0);
        check("rst_evt", {31'd0, evt_valid}, 32'd0);
        check_shadow(0, 8'h20);
        check_shadow(31, 8'h20);

        // Init sequence
        instr(8'h3C);
        instr(8'h0C);
        instr(8'h06);
        check("init_func", {29'd0, func}, 32'h7);
        check("init_disp", {31'd0, disp_on}, 32'd1);
        check("init_entry", {31'd0, entry_id}, 32'd1);
        check("init_err", {31'd0, err}, 32'd0);

        // Line 1 fill, line 2 first char
        instr(8'h80);
        for (int i = 0; i < 16; i++) wdata(8'(8'h41 + i));
        check("fill_cursor", {25'd0, cursor}, 32'h10);
        for (int i = 0; i < 16; i++) check_shadow(i, 8'(8'h41 + i));
        instr(8'hC0);
        wdata(8'h54);
        check_shadow(16, 8'h54);
        check("line2_cursor", {25'd0, cursor}, 32'h41);

        // Read transfer is ignored
        bus_write(1'b1, 1'b1, 8'h77, 40, 1'b0);
        check("rw1_cursor", {25'd0, cursor}, 32'h41);
        check("rw1_err", {31'd0, err}, 32'd0);
        check_shadow(17, 8'h20);

        // Wraps and out-of-map discards
        instr(8'hA7);
        wdata(8'h58);
        check("wrap_27_40", {25'd0, cursor}, 32'h40);
        instr(8'hE7);
        wdata(8'h58);
        check("wrap_67_00", {25'd0, cursor}, 32'h00);
        check_shadow(0, 8'h41);
        check_shadow(16, 8'h54);
        instr(8'h04);
        check("entry_dec", {31'd0, entry_id}, 32'd0);
        instr(8'hC0);
        wdata(8'h59);
        check_shadow(16, 8'h59);
        check("dec_40_27", {25'd0, cursor}, 32'h27);
        instr(8'h14);
        check("shift_right", {25'd0, cursor}, 32'h40);
        instr(8'h10);
        check("shift_left", {25'd0, cursor}, 32'h27);
        instr(8'hB0);
        wdata(8'h33);
        check("oom_step", {25'd0, cursor}, 32'h2F);

        // Busy collision: second write lands inside the 37-cycle window
        instr(8'h06);
        instr(8'h80);
        bus_write(1'b1, 1'b0, 8'h61, 0, 1'b1);
        bus_write(1'b1, 1'b0, 8'h62, 40, 1'b0);
        check("drop_err", {31'd0, err}, 32'd1);
        check("drop_cursor", {25'd0, cursor}, 32'h01);
        check_shadow(0, 8'h61);
        check_shadow(1, 8'h42);
        wdata(8'h63);
        wdata(8'h64);
        check_shadow(1, 8'h63);
        check_shadow(2, 8'h64);
        check("spaced_cursor", {25'd0, cursor}, 32'h03);

        // Clear display
        instr(8'hC5);
        wdata(8'h5A);
        check_shadow(21, 8'h5A);
        instr(8'h04);
        bus_write(1'b0, 1'b0, 8'h01, 0, 1'b1);
        measure_busy(nbusy);
        check("clear_busy_cycles", nbusy, 1520);
        for (int i = 0; i < 32; i++) check_shadow(i, 8'h20);
        check("clear_cursor", {25'd0, cursor}, 32'h00);
        check("clear_entry", {31'd0, entry_id}, 32'd1);

        // Return home
        instr(8'h85);
        bus_write(1'b0, 1'b0, 8'h02, 0, 1'b1);
        measure_busy(nbusy);
        check("home_busy_cycles", nbusy, 1520);
        check("home_cursor", {25'd0, cursor}, 32'h00);

        // Reset during CLEARING
        instr(8'hC5);
        wdata(8'h5A);
        instr(8'h04);
        bus_write(1'b0, 1'b0, 8'h01, 0, 1'b1);
        waited = 0;
        while (!busy && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        check("clear_start_seen", {31'd0, busy}, 32'd1);
        repeat (10) @(negedge clk);
        check("mid_clear_state", {30'd0, dbg_state}, 32'd1);
        check_shadow(21, 8'h5A);
        rst_n = 1'b0;
        #1;
        check("mrst_cursor", {25'd0, cursor}, 32'h00);
        check("mrst_busy", {31'd0, busy}, 32'd0);
        check("mrst_err", {31'd0, err}, 32'd0);
        check("mrst_func", {29'd0, func}, 32'd0);
        check("mrst_disp", {31'd0, disp_on}, 32'd0);
        check("mrst_entry", {31'd0, entry_id}, 32'd1);
        check("mrst_evt", {31'd0, evt_valid}, 32'd0);
        check_shadow(21, 8'h20);
        check_shadow(0, 8'h20);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check("post_rst_busy", {31'd0, busy}, 32'd0);

        // Instruction 0x00 flags an error and changes nothing else
        instr(8'h85);
        bus_write(1'b0, 1'b0, 8'h00, 40, 1'b1);
        check("zero_err", {31'd0, err}, 32'd1);
        check("zero_cursor", {25'd0, cursor}, 32'h05);
        check("zero_func", {29'd0, func}, 32'd0);

        // Final report
        repeat (20) @(negedge clk);
        check("exp_q_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
